// File: rtl/pmod_keypad_if.sv
// rtl/pmod_keypad_if.sv - key event stream between the keypad scanner and its consumer
interface pmod_keypad_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] ev_code;
    logic       ev_press;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_press,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_press,
        output ev_ready
    );
endinterface

// File: rtl/pmod_keypad.sv
// rtl/pmod_keypad.sv - 4x4 matrix keypad scanner with frame debounce and press/release event queue
module pmod_keypad #(
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic          clk,
    input  logic          rst,
    output logic [3:0]    col_n,
    input  logic [3:0]    row_n,
    output logic [15:0]   keys,
    output logic          scan_done,
    pmod_keypad_if.master ev
);
    localparam int PW = $clog2(SETTLE);
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    logic          started;
    logic [1:0]    col;
    logic [PW-1:0] phase;
    logic [15:0]   raw;
    logic [15:0]   prev;
    logic          have_prev;
    logic [SW-1:0] stable;
    logic [SW-1:0] stable_nx;
    logic [15:0]   pending;
    logic          commit;
    logic [15:0]   commit_mask;
    logic          sel_any;
    logic [3:0]    sel_idx;
    logic [15:0]   sel_mask;

    // Two-flop synchronizer for the asynchronous row sense lines (idle = all high).
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
        end
    end

    // Column scanner: drive one column low for SETTLE cycles, sample its rows on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            started   <= 1'b0;
            col       <= 2'd0;
            phase     <= '0;
            col_n     <= 4'hF;
            raw       <= 16'h0000;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (!started) begin
                started <= 1'b1;
                col     <= 2'd0;
                phase   <= '0;
                col_n   <= 4'b1110;
            end else if (phase == PHASE_LAST) begin
                raw[{col, 2'b00} +: 4] <= ~row_s2;
                phase <= '0;
                col   <= col + 2'd1;
                col_n <= ~(4'b0001 << (col + 2'd1));
                if (col == 2'd3) begin
                    scan_done <= 1'b1;
                end
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Stability count for the frame just completed, and whether it commits a change.
    always_comb begin
        stable_nx = stable;
        if (!have_prev || raw != prev) begin
            stable_nx = SW'(1);
        end else if (stable != STABLE_MAX) begin
            stable_nx = stable + 1'b1;
        end
        commit      = scan_done && (stable_nx >= STABLE_MAX) && (raw != keys);
        commit_mask = commit ? (keys ^ raw) : 16'h0000;
    end

    // Lowest-numbered pending key is offered whenever the output slot is empty.
    always_comb begin
        sel_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = 4'(i);
            end
        end
        sel_any  = !ev.ev_valid && (pending != 16'h0000);
        sel_mask = sel_any ? (16'h0001 << sel_idx) : 16'h0000;
    end

    // Debounce commit, pending mask (a commit re-arms a bit cleared by selection) and event output.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev        <= 16'h0000;
            have_prev   <= 1'b0;
            stable      <= '0;
            keys        <= 16'h0000;
            pending     <= 16'h0000;
            ev.ev_valid <= 1'b0;
            ev.ev_code  <= 4'd0;
            ev.ev_press <= 1'b0;
        end else begin
            if (scan_done) begin
                prev      <= raw;
                have_prev <= 1'b1;
                stable    <= stable_nx;
                if (commit) begin
                    keys <= raw;
                end
            end
            pending <= (pending & ~sel_mask) | commit_mask;
            if (ev.ev_valid && ev.ev_ready) begin
                ev.ev_valid <= 1'b0;
            end else if (sel_any) begin
                ev.ev_valid <= 1'b1;
                ev.ev_code  <= sel_idx;
                ev.ev_press <= keys[sel_idx];
            end
        end
    end
endmodule

// File: tb/tb_pmod_keypad.sv
// tb/tb_pmod_keypad.sv - scoreboard bench for pmod_keypad with a behavioural keypad matrix
module tb_pmod_keypad;
    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] keys;
    logic        scan_done;
    logic [15:0] held = 16'h0000;

    pmod_keypad_if ev_if ();

    pmod_keypad #(.SETTLE(4), .DEBOUNCE(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .keys      (keys),
        .scan_done (scan_done),
        .ev        (ev_if)
    );

    int  n_cmp = 0;
    int  n_fail = 0;
    int  ev_count = 0;
    int  ev3_count = 0;
    ev_t exp_q[$];

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [3:0] prev_code = 4'd0;
    logic       prev_press = 1'b0;

    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (held[c*4+r] && (col_n[c] == 1'b0)) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted event and checks hold-while-stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_stable", {ev_if.ev_valid, ev_if.ev_code, ev_if.ev_press},
                      {1'b1, prev_code, prev_press});
            end
            if (ev_if.ev_valid && ev_if.ev_ready) begin
                ev_count++;
                if (ev_if.ev_code == 4'd3) ev3_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {ev_if.ev_code, ev_if.ev_press}, 5'h1f);
                    if ({ev_if.ev_code, ev_if.ev_press} == 5'h1f) begin
                        n_fail++;
                        $display("FAIL unexpected_event: got %h expected none", {ev_if.ev_code, ev_if.ev_press});
                    end
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event", {27'd0, ev_if.ev_code, ev_if.ev_press}, {27'd0, e.code, e.press});
                end
            end
            prev_valid = ev_if.ev_valid;
            prev_ready = ev_if.ev_ready;
            prev_code  = ev_if.ev_code;
            prev_press = ev_if.ev_press;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_scan_done();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!scan_done && n < 40);
        if (!scan_done) check("scan_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_keys(input string name, input logic [15:0] want, input logic [15:0] mask);
        int n = 0;
        while (((keys & mask) !== want) && n < 150) begin
            tick();
            n++;
        end
        check(name, keys & mask, want);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!ev_if.ev_valid && n < 150) begin
            tick();
            n++;
        end
        check(name, ev_if.ev_valid, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  pulses;
        int  last;
        bit  bad;
        int  base;
        int  base3;

        // Reset state
        ev_if.ev_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_col_n", col_n, 4'hF);
        check("rst_keys", keys, 16'h0);
        check("rst_scan_done", scan_done, 1'b0);
        check("rst_ev", {ev_if.ev_valid, ev_if.ev_code, ev_if.ev_press}, 6'h0);

        // Idle scanning: column order, 4 cycles each, scan_done every 16 cycles
        rst = 1'b0;
        tick();
        check("first_col", col_n, 4'b1110);
        pulses = 0;
        last = -1;
        bad = 1'b0;
        for (int k = 0; k < 176; k++) begin
            if (col_n !== ~(4'b0001 << ((k / 4) % 4))) bad = 1'b1;
            if (scan_done) begin
                if (last >= 0 && (k - last) != 16) bad = 1'b1;
                pulses++;
                last = k;
            end
            if (k != 175) tick();
        end
        check("col_seq_and_period", bad, 1'b0);
        check("scan_pulses", pulses, 10);
        check("idle_keys", keys, 16'h0);
        check("idle_events", ev_count, 0);

        // Key col2,row1 -> index 9, committed on the 3rd frame end
        wait_scan_done();
        held[9] = 1'b1;
        exp_q.push_back('{code: 4'd9, press: 1'b1});
        wait_scan_done();
        tick();
        check("k9_after_f1", keys, 16'h0);
        wait_scan_done();
        tick();
        check("k9_after_f2", keys, 16'h0);
        wait_scan_done();
        tick();
        check("k9_after_f3", keys, 16'h0200);
        wait_drain(100);
        held[9] = 1'b0;
        exp_q.push_back('{code: 4'd9, press: 1'b0});
        wait_keys("k9_release", 16'h0, 16'hFFFF);
        wait_drain(100);

        // Bouncing key 5, then held
        wait_scan_done();
        repeat (3) tick();
        bad = 1'b0;
        for (int i = 0; i < 96; i++) begin
            held[5] = ((i / 10) % 2) == 0;
            if (keys !== 16'h0) bad = 1'b1;
            tick();
        end
        check("bounce_no_change", bad, 1'b0);
        check("bounce_no_event", ev_count, 2);
        held[5] = 1'b1;
        exp_q.push_back('{code: 4'd5, press: 1'b1});
        wait_keys("k5_press", 16'h0020, 16'hFFFF);
        wait_drain(100);
        held[5] = 1'b0;
        exp_q.push_back('{code: 4'd5, press: 1'b0});
        wait_keys("k5_release", 16'h0, 16'hFFFF);
        wait_drain(100);

        // Keys 0 and 15 together with the consumer stalled
        base = ev_count;
        ev_if.ev_ready = 1'b0;
        held[0] = 1'b1;
        held[15] = 1'b1;
        exp_q.push_back('{code: 4'd0, press: 1'b1});
        exp_q.push_back('{code: 4'd15, press: 1'b1});
        wait_valid("k0_15_valid");
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ({ev_if.ev_valid, ev_if.ev_code, ev_if.ev_press} !== {1'b1, 4'd0, 1'b1}) bad = 1'b1;
            tick();
        end
        check("stall_hold_k0", bad, 1'b0);
        ev_if.ev_ready = 1'b1;
        wait_drain(50);
        repeat (20) tick();
        check("k0_15_count", ev_count - base, 2);

        // Key 3 pressed and released while the output is occupied: one collapsed event
        base3 = ev3_count;
        ev_if.ev_ready = 1'b0;
        held[0] = 1'b0;
        held[15] = 1'b0;
        exp_q.push_back('{code: 4'd0, press: 1'b0});
        exp_q.push_back('{code: 4'd3, press: 1'b0});
        exp_q.push_back('{code: 4'd15, press: 1'b0});
        wait_valid("rel_valid");
        held[3] = 1'b1;
        wait_keys("k3_press", 16'h0008, 16'h0008);
        held[3] = 1'b0;
        wait_keys("k3_release", 16'h0, 16'h0008);
        ev_if.ev_ready = 1'b1;
        wait_drain(50);
        repeat (20) tick();
        check("k3_single_event", ev3_count - base3, 1);

        // Reset mid-frame (column 1, phase 2) with an event presented and another pending
        ev_if.ev_ready = 1'b0;
        held[9] = 1'b1;
        held[10] = 1'b1;
        wait_valid("pre_rst_valid");
        held[9] = 1'b0;
        held[10] = 1'b0;
        wait_scan_done();
        repeat (6) tick();
        check("pre_rst_col", col_n, 4'b1101);
        rst = 1'b1;
        tick();
        check("mid_rst_col_n", col_n, 4'hF);
        check("mid_rst_keys", keys, 16'h0);
        check("mid_rst_valid", ev_if.ev_valid, 1'b0);
        rst = 1'b0;
        tick();
        check("restart_col0", col_n, 4'b1110);
        repeat (4) tick();
        check("restart_col1", col_n, 4'b1101);
        ev_if.ev_ready = 1'b1;
        repeat (200) tick();
        check("post_rst_no_events", exp_q.size(), 0);
        check("post_rst_keys", keys, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
